mc_ctrl: RTL

- Multi-cycle MIPS control unit; the driving end of the ALU control interface.
- Sequences FETCH/DECODE/EXEC/MEM/WB, decodes opcode/funct from the instruction register, drives alu_op, mux selects and write strobes.
- Consumes the ALU's beq_flag to resolve branches.
- Keeps retired-instruction and cycle counters for bench/debug.

---
 rtl/mc_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB, decodes the
// instruction register fields and drives ALU control, mux selects and write strobes.
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             beq_flag,
  output logic [2:0]       state,
  output logic             pc_we,
  output logic             ir_we,
  output logic             reg_we,
  output logic             mem_we,
  output logic [2:0]       alu_op,
  output logic             alusrc,
  output logic             ext_op,
  output logic [1:0]       regdst,
  output logic [1:0]       memtoreg,
  output logic [1:0]       npc_sel,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    C_ADDU, C_SUBU, C_JR, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_OTHER
  } cls_t;

  state_t     cur, nxt;
  cls_t       cls;
  logic       pc_we_c, ir_we_c, reg_we_c, mem_we_c;
  logic [2:0] alu_op_c;
  logic       alusrc_c, ext_op_c;
  logic [1:0] regdst_c, memtoreg_c, npc_sel_c;

  assign state = cur;

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    cls = C_OTHER;
    case (opcode)
      6'b000000: begin
        case (funct)
          6'b100001: cls = C_ADDU;
          6'b100011: cls = C_SUBU;
          6'b001000: cls = C_JR;
          default:   cls = C_OTHER;
        endcase
      end
      6'b001101: cls = C_ORI;
      6'b001111: cls = C_LUI;
      6'b100011: cls = C_LW;
      6'b101011: cls = C_SW;
      6'b000100: cls = C_BEQ;
      6'b000010: cls = C_J;
      6'b000011: cls = C_JAL;
      default:   cls = C_OTHER;
    endcase
  end

  always_comb begin
    nxt        = S_FETCH;
    pc_we_c    = 1'b0;
    ir_we_c    = 1'b0;
    reg_we_c   = 1'b0;
    mem_we_c   = 1'b0;
    alu_op_c   = 3'b010;
    alusrc_c   = 1'b0;
    ext_op_c   = 1'b1;
    regdst_c   = 2'b00;
    memtoreg_c = 2'b00;
    npc_sel_c  = 2'b00;
    case (cur)
      S_FETCH: begin
        ir_we_c = 1'b1;
        pc_we_c = 1'b1;
        nxt     = S_DECODE;
      end
      S_DECODE: begin
        case (cls)
          C_J: begin
            pc_we_c   = 1'b1;
            npc_sel_c = 2'b10;
          end
          C_JAL: begin
            pc_we_c    = 1'b1;
            npc_sel_c  = 2'b10;
            reg_we_c   = 1'b1;
            regdst_c   = 2'b10;
            memtoreg_c = 2'b10;
          end
          C_JR: begin
            pc_we_c   = 1'b1;
            npc_sel_c = 2'b11;
          end
          C_OTHER: nxt = S_FETCH;
          default: nxt = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (cls)
          C_ADDU: nxt = S_WB;
          C_SUBU: begin
            alu_op_c = 3'b011;
            nxt      = S_WB;
          end
          C_ORI: begin
            alu_op_c = 3'b001;
            alusrc_c = 1'b1;
            ext_op_c = 1'b0;
            nxt      = S_WB;
          end
          C_LUI: begin
            alu_op_c = 3'b110;
            alusrc_c = 1'b1;
            nxt      = S_WB;
          end
          C_LW, C_SW: begin
            alusrc_c = 1'b1;
            nxt      = S_MEM;
          end
          C_BEQ: begin
            alu_op_c = 3'b011;
            if (beq_flag) begin
              pc_we_c   = 1'b1;
              npc_sel_c = 2'b01;
            end
          end
          default: nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        alusrc_c = 1'b1;
        if (cls == C_SW) mem_we_c = 1'b1;
        else if (cls == C_LW) nxt = S_WB;
      end
      S_WB: begin
        reg_we_c   = 1'b1;
        regdst_c   = (cls == C_ADDU || cls == C_SUBU) ? 2'b01 : 2'b00;
        memtoreg_c = (cls == C_LW) ? 2'b01 : 2'b00;
      end
      default: nxt = S_FETCH;
    endcase
  end

  // Reset gates the outputs combinationally so a strobe dies the moment reset_n falls.
  assign pc_we    = reset_n & pc_we_c;
  assign ir_we    = reset_n & ir_we_c;
  assign reg_we   = reset_n & reg_we_c;
  assign mem_we   = reset_n & mem_we_c;
  assign alu_op   = reset_n ? alu_op_c   : 3'b010;
  assign alusrc   = reset_n & alusrc_c;
  assign ext_op   = reset_n & ext_op_c;
  assign regdst   = reset_n ? regdst_c   : 2'b00;
  assign memtoreg = reset_n ? memtoreg_c : 2'b00;
  assign npc_sel  = reset_n ? npc_sel_c  : 2'b00;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur       <= S_FETCH;
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cur       <= nxt;
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (nxt == S_FETCH && cur != S_FETCH) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

endmodule
